// File: rtl/sub_serie.sv
`default_nettype none
// ============================================================================
//  Module   : sub_serie
//  Purpose  : Bit-serial subtractor. Computes s = a - b - rin (mod 2^N) with a
//             single full-subtractor cell, one bit per clock, LSB first. It
//             also reports the final borrow (rout).
//  Options  : SUB_SERIE_OVF_EN - adds the ovf output, which reports two's-
//             complement overflow of the difference.
//  Revision : 1.0 - initial release
// ============================================================================
//
//  Timing for a start sampled at edge k:
//    edges k+1 .. k+N : one difference bit per edge (internal RUN state)
//    edge  k+N        : last bit, s/rout final, internal state -> DONE
//    edge  k+N+1      : DONE -> IDLE, done output rises (registered)
//    edge  k+N+2      : done falls; IDLE may already accept the next start
//  This gives a throughput of one result every N+2 cycles.
//  busy covers the whole window from edge k to edge k+N+2, including the
//  done cycle.

module sub_serie #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         rin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         rout
`ifdef SUB_SERIE_OVF_EN
  ,
  output logic         ovf
`endif
);

  // Bit counter width; N >= 2 keeps this at least 1.
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_a;      // minuend, shifted right so bit 0 is current
  logic [N-1:0]   r_b;      // subtrahend, shifted right likewise
  logic [N-1:0]   r_s;      // difference bits enter at the MSB end
  logic [CW-1:0]  r_cnt;    // index of the bit being processed
  logic           r_br;     // borrow carried between bit cycles
  logic           r_rout;
  logic           r_busy;
  logic           r_done;
`ifdef SUB_SERIE_OVF_EN
  logic           r_ovf;
`endif

  logic           w_d;
  logic           w_br_next;
  logic           w_last;

  // Full-subtractor cell working on the current LSBs of the operands.
  always_comb begin
    w_d       = r_a[0] ^ r_b[0] ^ r_br;
    w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    w_last    = (r_cnt == CW'(N - 1));
  end

  // Control FSM, serial datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_rout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SUB_SERIE_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      // The done pulse trails the internal DONE state by one cycle. This lets
      // IDLE overlap the pulse cycle and keeps the cadence at N+2.
      r_done <= (r_state == DONE);

      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= rin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else if (r_done) begin
            // Result has been presented; drop busy with the done pulse.
            r_busy <= 1'b0;
          end
        end

        RUN: begin
          r_s   <= {w_d, r_s[N-1:1]};
          r_a   <= {1'b0, r_a[N-1:1]};
          r_b   <= {1'b0, r_b[N-1:1]};
          r_br  <= w_br_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_rout  <= w_br_next;
`ifdef SUB_SERIE_OVF_EN
            // Overflow = borrow into the sign bit XOR borrow out of it.
            r_ovf   <= r_br ^ w_br_next;
`endif
            r_state <= DONE;
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are driven straight from registers.
  always_comb begin
    busy = r_busy;
    done = r_done;
    s    = r_s;
    rout = r_rout;
`ifdef SUB_SERIE_OVF_EN
    ovf  = r_ovf;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_sub_serie.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sub_serie
//  Purpose  : Self-checking bench for sub_serie (N=8). An arithmetic reference
//             model predicts busy/done/s/rout(/ovf) every cycle. Directed
//             cases pin known values, latency, start-ignore and reset abort.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sub_serie;

  localparam int N = 8;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic         rin   = 1'b0;
  logic [N-1:0] a     = '0;
  logic [N-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic         rout;
  logic [N-1:0] s;
`ifdef SUB_SERIE_OVF_EN
  logic         ovf;
`endif

  sub_serie #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .rin   (rin),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .rout  (rout)
`ifdef SUB_SERIE_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: plain integer subtraction, unsigned and signed views.
  function automatic void ref_sub(input logic [N-1:0] x, input logic [N-1:0] y, input logic c,
                                  output logic [N-1:0] d, output bit bo, output bit ov);
    int ux, uy, sx, sy, ci, diff;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    ci = c ? 1 : 0;
    diff = sx - sy - ci;
    d  = N'(ux - uy - ci);
    bo = (ux < uy + ci);
    ov = (diff < -(1 << (N - 1))) || (diff > (1 << (N - 1)) - 1);
  endfunction

  // Model state. m_* is the last presented result; p_* is the one in flight.
  int           cyc    = 0;
  bit           m_act  = 1'b0;
  int           m_k    = 0;
  logic [N-1:0] m_s    = '0;
  bit           m_rout = 1'b0;
  bit           m_ovf  = 1'b0;
  logic [N-1:0] p_s    = '0;
  bit           p_rout = 1'b0;
  bit           p_ovf  = 1'b0;
  bit           chk_en = 1'b0;

  // Model update on every rising edge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_act  = 1'b0;
      m_s    = '0;
      m_rout = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      if (m_act && cyc == m_k + N + 1) begin
        m_s    = p_s;
        m_rout = p_rout;
        m_ovf  = p_ovf;
      end
      if (m_act && cyc >= m_k + N + 2) m_act = 1'b0;
      if (!m_act && start) begin
        m_act = 1'b1;
        m_k   = cyc;
        ref_sub(a, b, rin, p_s, p_rout, p_ovf);
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (rst) begin
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_s",    32'(s),    32'(0));
        chk("rst_rout", 32'(rout), 32'(0));
      end else begin
        chk("busy", 32'(busy), 32'(m_act && cyc <= m_k + N + 1));
        chk("done", 32'(done), 32'(m_act && cyc == m_k + N + 1));
        if (!(m_act && cyc < m_k + N + 1)) begin
          chk("s",    32'(s),    32'(m_s));
          chk("rout", 32'(rout), 32'(m_rout));
`ifdef SUB_SERIE_OVF_EN
          chk("ovf",  32'(ovf),  32'(m_ovf));
`endif
        end
      end
    end
  end

  task automatic do_start(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    @(negedge clk);
    a     = x;
    b     = y;
    rin   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the number of falling edges until done is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic lit_op(input string nm, input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic c, input logic [N-1:0] es, input logic er);
    int n;
    do_start(x, y, c);
    wait_done(n);
    chk({nm, "_latency"}, 32'(n), 32'(N + 1));
    chk({nm, "_s"},       32'(s),    32'(es));
    chk({nm, "_rout"},    32'(rout), 32'(er));
    @(negedge clk);
    chk({nm, "_done_fall"}, 32'(done), 32'(0));
  endtask

  initial begin
    logic [N-1:0] ms;
    bit           mb, mo;
    int           nd;
    logic [N-1:0] s_seen;
    logic         r_seen;

    // Pin the reference model on hand-computed values.
    ref_sub(8'h80, 8'h01, 1'b0, ms, mb, mo);
    chk("model_80_01_s", 32'(ms), 32'h7F);
    chk("model_80_01_ovf", 32'(mo), 32'd1);
    ref_sub(8'h00, 8'h01, 1'b0, ms, mb, mo);
    chk("model_00_01_s", 32'(ms), 32'hFF);
    chk("model_00_01_borrow", 32'(mb), 32'd1);
    chk("model_00_01_ovf", 32'(mo), 32'd0);

    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_s",    32'(s),    32'(0));
    chk("reset_rout", 32'(rout), 32'(0));

    // Directed cases; the first start lands on the first edge after reset.
    lit_op("sub_50_20", 8'h50, 8'h20, 1'b0, 8'h30, 1'b0);
    lit_op("sub_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
`ifdef SUB_SERIE_OVF_EN
    chk("sub_00_01_ovf", 32'(ovf), 32'd0);
`endif
    lit_op("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
`ifdef SUB_SERIE_OVF_EN
    chk("sub_80_01_ovf", 32'(ovf), 32'd1);
`endif
    lit_op("sub_3C_3C_rin", 8'h3C, 8'h3C, 1'b1, 8'hFF, 1'b1);

    // A start pulse in RUN cycle 3 must be ignored.
    do_start(8'h50, 8'h20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a = 8'h11; b = 8'h99; rin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    s_seen = '0;
    r_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) begin
        nd++;
        s_seen = s;
        r_seen = rout;
      end
    end
    chk("ignore_done_pulses", 32'(nd), 32'd1);
    chk("ignore_s", 32'(s_seen), 32'h30);
    chk("ignore_rout", 32'(r_seen), 32'd0);

    // Reset in RUN cycle 4 aborts the operation with no done pulse.
    do_start(8'h5A, 8'h33, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_s",    32'(s),    32'(0));
    chk("abort_rout", 32'(rout), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    lit_op("after_abort", 8'h5A, 8'h33, 1'b0, 8'h27, 1'b0);

    // Randomised traffic: isolated operations with random gaps.
    repeat (25) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_start(N'($urandom), N'($urandom), 1'($urandom));
      wait_done(nd);
      chk("rand_latency", 32'(nd), 32'(N + 1));
    end

    // Start held high with operands changing every cycle (back-to-back).
    @(negedge clk);
    start = 1'b1;
    repeat (4 * (N + 2)) begin
      @(negedge clk);
      a = N'($urandom); b = N'($urandom); rin = 1'($urandom);
    end
    start = 1'b0;

    // Random start noise, including pulses during RUN and DONE.
    repeat (400) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      a = N'($urandom); b = N'($urandom); rin = 1'($urandom);
    end
    start = 1'b0;
    repeat (N + 4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sub_serie.md
SUB_SERIE -- requirements
Module: sub_serie

Interface
REQ-001 SHALL have parameter N, default 8, operand and result width in bits; N >= 2.
REQ-002 SHALL have port clk  input  1  single clock; every register updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to subtract; sampled only in IDLE.
REQ-005 SHALL have port a  input  N  minuend; captured on accepted start.
REQ-006 SHALL have port b  input  N  subtrahend; captured on accepted start.
REQ-007 SHALL have port rin  input  1  borrow in; captured on accepted start.
REQ-008 SHALL have port busy  output  1  high in RUN and DONE.
REQ-009 SHALL have port done  output  1  one-cycle pulse; s and rout are valid.
REQ-010 SHALL have port s  output  N  difference a - b - rin, modulo 2^N.
REQ-011 SHALL have port rout  output  1  borrow out; high when a < b + rin (unsigned).

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: start=1 at an edge SHALL capture a, b and rin, clear the bit counter, and go to RUN.
REQ-014 RUN SHALL use one full-subtractor cell, bit i per cycle, LSB first: d = a[i]^b[i]^br; br_next = (~a[i]&b[i]) | (~(a[i]^b[i])&br).
REQ-015 The cell's borrow SHALL be seeded from the captured rin and SHALL be registered between bits.
REQ-016 Each difference bit SHALL shift into the result register; after N RUN edges, s SHALL hold the full difference.
REQ-017 After the N-th RUN edge, rout SHALL hold the final borrow and the FSM SHALL enter DONE.
REQ-018 Latency: start sampled at edge k; done SHALL be high from edge k+N+1 to edge k+N+2.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-020 start SHALL be ignored in RUN and DONE; operands SHALL NOT change mid-operation.
REQ-021 s and rout SHALL hold their last result in IDLE until the next accepted start.
REQ-022 Intermediate s values during RUN are undefined; consumers SHALL use s only when done=1 or in IDLE after done.
REQ-023 Back-to-back operation: start held high SHALL begin a new operation on the edge after DONE; throughput is one result per N+2 cycles.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, busy=0, done=0, s=0, rout=0, and clear the bit counter and internal borrow, regardless of clock.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-026 The first start SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-027 Macro SUB_SERIE_OVF_EN defined: port ovf  output  1 SHALL exist. ovf = two's-complement overflow of a - b - rin, computed as the borrow into bit N-1 XOR the borrow out of bit N-1.
REQ-028 ovf SHALL be valid and held exactly like rout and SHALL reset to 0.
REQ-029 Macro SUB_SERIE_OVF_EN undefined: the ovf port and its logic SHALL NOT exist; all other behaviour SHALL be identical.

Verification (N=8)
REQ-030 Bench SHALL check a=0x50, b=0x20, rin=0 -> done 9 edges after start edge, s=0x30, rout=0.
REQ-031 Bench SHALL check a=0x00, b=0x01, rin=0 -> s=0xFF, rout=1; with SUB_SERIE_OVF_EN, ovf=0.
REQ-032 Bench SHALL check a=0x80, b=0x01, rin=0 with SUB_SERIE_OVF_EN -> s=0x7F, rout=0, ovf=1.
REQ-033 Bench SHALL check a=b=0x3C, rin=1 -> s=0xFF, rout=1.
REQ-034 Bench SHALL check start pulsed at RUN cycle 3 with different operands -> ignored; first result unchanged; exactly one done pulse.
REQ-035 Bench SHALL check rst asserted at RUN cycle 4 -> outputs zero immediately, no done; a new start then produces a correct result.
